adc_sample_packer: RTL and testbench
====================================

# adc_sample_packer

Front-end ingest block for the receive path: captures unsigned 8-bit offset-binary ADC samples, re-centres them to signed, applies a programmable power-of-two gain, and presents them as 64-bit signed AXI-Stream beats to the FIR filter input. It is the inverse of the output stage that converts FIR results back to 8-bit offset-binary for the DAC. A small FIFO absorbs downstream backpressure. Overflow is flagged and counted, never silently merged.

## Interface
- C_M00_AXIS_TDATA_WIDTH, 64, output beat width; one sample per beat.
- ADC_WIDTH, 8, ADC sample width, offset-binary.
- FIFO_DEPTH, 4, sample buffer depth; power of two, at least 2.
- FRAME_LEN, 1024, accepted samples per frame; m00_axis_tlast marks the last one.
- m00_axis_aclk  in  1  single clock for the whole block.
- m00_axis_areset  in  1  synchronous, active-high reset.
- adc_data  in  ADC_WIDTH  raw ADC sample, offset-binary; 128 represents zero.
- adc_valid  in  1  one-cycle strobe that qualifies adc_data.
- shift  in  4  left-shift gain applied to the centred sample; sampled together with adc_data.
- overflow_clear  in  1  pulse that clears the overflow flag.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  beat valid.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  signed, sign-extended sample.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all-ones.
- m00_axis_tlast  out  1  frame boundary marker.
- overflow  out  1  sticky; set when a sample is dropped.
- drop_count  out  16  saturating count of dropped samples.

## Operation
- **Conversion**, combinational at capture:
  - centred = $signed({1'b0, adc_data}) - 128, 9-bit signed, range -128..127.
  - scaled = centred <<< shift, sign-extended to 64 bits.
  - Worst-case magnitude is 2^22, so the result never overflows.
  - Examples: adc_data = 0 gives -128<<shift; adc_data = 255 gives 127<<shift.
- **Write side:** a write is attempted on every cycle where adc_valid = 1.
  - If the FIFO is not full, or is full but pops this cycle, the sample is accepted.
  - The FIFO entry stores {tlast_bit, scaled}.
- **Frame counter:** ranges 0..FRAME_LEN-1 and advances only on accepted samples.
  - tlast_bit = 1 when the counter equals FRAME_LEN-1; the counter then wraps to 0.
- **Drop rule:** a sample is dropped only when the FIFO is full and there is no pop in the same cycle.
  - On a drop: overflow is set, drop_count increments and saturates at 16'hFFFF.
  - The frame counter does not advance on a drop.
- **overflow_clear:** clears overflow. If a drop occurs in the same cycle, set wins and overflow stays 1. drop_count is cleared only by reset.
- **Read side:**
  - m00_axis_tvalid = FIFO not empty.
  - m00_axis_tdata and m00_axis_tlast come from the head entry.
  - A pop occurs when tvalid && tready.
- **Occupancy:** simultaneous push and pop leaves occupancy unchanged, including at full and at empty.
  - At empty, a push and pop cannot coincide, because tvalid = 0.
- **Head stability:** tdata and tlast must stay stable while tvalid = 1 and tready = 0.
- **Empty state:** when the FIFO is empty, tdata holds its last value; consumers must ignore it.
- **Pointers:** read and write pointers wrap modulo FIFO_DEPTH. An occupancy counter of width clog2(FIFO_DEPTH)+1 disambiguates full from empty.

## Timing
- **Reset values:** tvalid = 0, tdata = 0, tlast = 0, overflow = 0, drop_count = 0, frame counter = 0, FIFO empty. tstrb is always all-ones.
- **Reset mid-operation:** buffered samples are discarded. Outputs take their reset values on the clock after reset is sampled high.
- **Latency:** a sample accepted at edge N is visible with tvalid = 1 after edge N, i.e. in cycle N+1, when the FIFO was empty. Otherwise it appears after all older entries.
- **Throughput:** one sample per cycle sustained when tready = 1.
- **Gain changes:** `shift` changes affect only samples captured afterwards; entries already buffered are unchanged.
- **overflow / drop_count** update on the edge that samples the dropping write.

## Test plan
- **Basic conversion:** reset, tready = 1, shift = 0; send adc_data 128, 0, 255 on consecutive cycles.
  - Expect tdata 0, -128 (64'hFFFF...FF80), 127, each one cycle after its strobe.
  - tvalid stays high for exactly 3 cycles.
- **Gain:** shift = 15, adc_data = 0 -> tdata = -4194304. Change shift to 4 with adc_data = 200 -> tdata = 1152.
- **Backpressure and overflow:** tready = 0; send 6 samples 1..6 at FIFO_DEPTH = 4.
  - Expect overflow = 1 and drop_count = 2.
  - After tready = 1, beats appear in order 1..4 (centred values -127..-124) and nothing more.
- **Full with simultaneous pop:** fill the FIFO, then hold tready = 1 and adc_valid = 1 in the same cycle.
  - No drop; drop_count is unchanged; occupancy stays 4.
- **Frame marking:** FRAME_LEN = 8; stream 20 samples with one drop injected at sample 5.
  - tlast is asserted on accepted samples 8 and 16 only; the dropped sample does not shift the frame.
- **Reset and clear:** assert reset with 3 entries buffered and overflow set -> tvalid = 0 and drop_count = 0 next cycle. Then force a drop in the same cycle as overflow_clear -> overflow remains 1.

Source files
------------

// File: rtl/adc_sample_packer.sv
// adc_sample_packer: centres offset-binary ADC samples, applies shift gain, buffers them as AXI-Stream beats
module adc_sample_packer #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int ADC_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN = 1024
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_areset,
  input  logic [ADC_WIDTH-1:0]                  adc_data,
  input  logic                                  adc_valid,
  input  logic [3:0]                            shift,
  input  logic                                  overflow_clear,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  output logic                                  overflow,
  output logic [15:0]                           drop_count
);
  localparam int W = C_M00_AXIS_TDATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  logic [W:0] mem [FIFO_DEPTH];
  logic [W:0] head, last_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [FW-1:0] frame;
  logic signed [ADC_WIDTH:0] centred;
  logic [W-1:0] scaled;
  logic full, empty, pop, push, drop, frame_last;
  assign centred = $signed({1'b0, adc_data}) - $signed({2'b01, {(ADC_WIDTH-1){1'b0}}});
  assign scaled = {{(W-ADC_WIDTH-1){centred[ADC_WIDTH]}}, centred} << shift;
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign pop = !empty && m00_axis_tready;
  assign push = adc_valid && (!full || pop);
  assign drop = adc_valid && full && !pop;
  assign frame_last = frame == FW'(FRAME_LEN - 1);
  assign head = mem[rd_ptr];
  // An empty FIFO shows the last popped beat so the output never changes to stale slot contents
  assign {m00_axis_tlast, m00_axis_tdata} = empty ? last_q : head;
  assign m00_axis_tvalid = !empty;
  assign m00_axis_tstrb = '1;
  // Sample storage; no reset needed since only occupied slots are ever observed
  always_ff @(posedge m00_axis_aclk)
    if (push) mem[wr_ptr] <= {frame_last, scaled};
  // Pointers, occupancy, frame position and overflow bookkeeping
  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      frame <= '0;
      last_q <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push) frame <= frame_last ? '0 : frame + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) last_q <= head;
      count <= count + CW'(push) - CW'(pop);
      overflow <= drop || (overflow && !overflow_clear);
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_adc_sample_packer.sv
// tb_adc_sample_packer: directed and random checks of adc_sample_packer against a queue model
module tb_adc_sample_packer;
  localparam int W = 64;
  localparam int D = 4;
  localparam int FL = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] adc_data = '0;
  logic adc_valid = 1'b0;
  logic [3:0] shift = '0;
  logic overflow_clear = 1'b0, tready = 1'b0;
  logic tvalid, tlast, overflow;
  logic [W-1:0] tdata;
  logic [W/8-1:0] tstrb;
  logic [15:0] drop_count;
  int total = 0, bad = 0;
  logic [W:0] q[$];
  logic [W:0] last = '0;
  int fc = 0, dc = 0;
  logic ov = 1'b0;
  int dut_beat = 0;
  int dut_tl[$];

  adc_sample_packer #(.C_M00_AXIS_TDATA_WIDTH(W), .ADC_WIDTH(8), .FIFO_DEPTH(D), .FRAME_LEN(FL)) dut (
    .m00_axis_aclk(clk), .m00_axis_areset(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .shift(shift), .overflow_clear(overflow_clear), .m00_axis_tready(tready),
    .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [W:0] h;
    h = q.size() != 0 ? q[0] : last;
    chk("tvalid", W'(tvalid), W'(q.size() != 0));
    chk("tdata", tdata, h[W-1:0]);
    chk("tlast", W'(tlast), W'(h[W]));
    chk("overflow", W'(overflow), W'(ov));
    chk("drop_count", W'(drop_count), W'(dc));
    chk("tstrb", W'(tstrb), W'(8'hFF));
  endtask

  task automatic step(input bit v, input int d, input int s, input bit r, input bit c, input bit rs = 1'b0);
    bit pop, drop;
    longint val;
    adc_valid = v;
    adc_data = 8'(d);
    shift = 4'(s);
    tready = r;
    overflow_clear = c;
    rst = rs;
    if (!rs && tvalid && r) begin
      dut_beat++;
      if (tlast) dut_tl.push_back(dut_beat);
    end
    @(posedge clk);
    if (rs) begin
      q.delete();
      fc = 0;
      dc = 0;
      ov = 1'b0;
      last = '0;
    end else begin
      pop = q.size() != 0 && r;
      drop = v && q.size() == D && !pop;
      if (pop) last = q.pop_front();
      if (v && !drop) begin
        val = longint'(d - 128) * (longint'(1) << s);
        q.push_back({fc == FL - 1, val});
        fc = (fc + 1) % FL;
      end
      if (drop) begin
        ov = 1'b1;
        if (dc < 65535) dc++;
      end else if (c) ov = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("reset_tdata", tdata, 0);
    step(1, 128, 0, 1, 0);
    chk("basic_128", tdata, 0);
    step(1, 0, 0, 1, 0);
    chk("basic_0", tdata, 64'hFFFF_FFFF_FFFF_FF80);
    step(1, 255, 0, 1, 0);
    chk("basic_255", tdata, 127);
    chk("basic_valid3", W'(tvalid), 1);
    step(0, 0, 0, 1, 0);
    chk("basic_valid_end", W'(tvalid), 0);
    step(1, 0, 15, 1, 0);
    chk("gain15", tdata, -4194304);
    step(1, 200, 4, 1, 0);
    chk("gain4", tdata, 1152);
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) step(1, i, 0, 0, 0);
    chk("bp_overflow", W'(overflow), 1);
    chk("bp_drops", W'(drop_count), 2);
    for (int k = 0; k < 4; k++) begin
      chk("bp_order", tdata, W'(-127 + k));
      step(0, 0, 0, 1, 0);
    end
    chk("bp_no_more", W'(tvalid), 0);
    for (int i = 0; i < 4; i++) step(1, 10 + i, 0, 0, 0);
    step(1, 50, 0, 1, 0);
    chk("fullpop_nodrop", W'(drop_count), 2);
    step(1, 51, 0, 0, 0);
    chk("fullpop_still_full", W'(drop_count), 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    dut_beat = 0;
    dut_tl.delete();
    for (int i = 1; i <= 20; i++) step(1, 100 + i, 0, i >= 6, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    chk("frame_beats", W'(dut_beat), 19);
    chk("frame_tlast_cnt", W'(dut_tl.size()), 2);
    if (dut_tl.size() == 2) begin
      chk("frame_tlast_a", W'(dut_tl[0]), 8);
      chk("frame_tlast_b", W'(dut_tl[1]), 16);
    end
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      step($urandom % 4 != 0, int'($urandom % 256), int'($urandom % 16), $urandom % 3 != 0, $urandom % 8 == 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 60 + i, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("rst_pre_ov", W'(overflow), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_tvalid", W'(tvalid), 0);
    chk("rst_drops", W'(drop_count), 0);
    chk("rst_overflow", W'(overflow), 0);
    for (int i = 0; i < 4; i++) step(1, 70 + i, 0, 0, 0);
    step(1, 80, 0, 0, 1);
    chk("clr_set_wins", W'(overflow), 1);
    step(0, 0, 0, 0, 1);
    chk("clr_clears", W'(overflow), 0);
    chk("clr_keeps_count", W'(drop_count), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
